gate_pulse_sequencer: RTL and testbench
=======================================

// Module: gate_pulse_sequencer
// PURPOSE
//  Downstream of the dummy scan engine: turns each row request (row address + strobe) into
//  gate-driver control waveforms: STV start pulse, CPV shift clock, OE output enable.
//  Serves normal readout and dummy/reset scans. Enforces setup, on-time and non-overlap
//  gap timing, and flags row requests the shift-register gate chain cannot follow.
// PARAMETERS
//  ROW_W     12    row address width
//  TW        16    on-time counter width
//  SW        8     setup/gap counter width
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous reset, active-high
//  row_strobe    in   1      1-cycle request to drive row_addr (dummy engine reset_pulse)
//  row_addr      in   ROW_W  row to drive, sampled with row_strobe
//  scan_mode     in   1      1 = dummy scan row, 0 = normal readout, sampled with row_strobe
//  cfg_t_setup   in   SW     CPV-high cycles before OE (0 treated as 1)
//  cfg_t_on      in   TW     OE-active cycles (0 treated as 1)
//  cfg_t_gap     in   SW     non-overlap cycles after OE (0 = no gap state)
//  cfg_num_rows  in   ROW_W  panel rows; row_addr >= cfg_num_rows is illegal
//  gate_stv      out  1      start-vertical pulse, high during SETUP of row 0 only
//  gate_cpv      out  1      gate shift clock, high during SETUP
//  gate_oe       out  1      gate output enable, high during ON
//  busy          out  1      row in progress (SETUP/ON/GAP)
//  row_done      out  1      1-cycle pulse after a row completes
//  cur_row       out  ROW_W  last accepted row
//  err_overrun   out  1      sticky: row_strobe while busy
//  err_seq       out  1      sticky: row not 0 and not previous+1, or row >= cfg_num_rows
// BEHAVIOUR
//  - Reset: FSM=IDLE; all outputs 0; cur_row=0; expected-next-row=0; sticky errors cleared.
//  - FSM: IDLE -> SETUP -> ON -> GAP -> DONE -> IDLE. cfg_t_gap=0 skips GAP (ON -> DONE).
//  - IDLE: row_strobe accepted in cycle N: latch row_addr, scan_mode, cfg; SETUP from N+1.
//  - SETUP: cpv=1, stv=(row==0), for max(cfg_t_setup,1) cycles.
//  - ON: cpv=0, stv=0, oe=1 for max(t_on,1) cycles.
//  - GAP: oe=0, cpv=0 for cfg_t_gap cycles.
//  - DONE: one cycle; row_done=1, busy=0. A row_strobe in DONE is accepted exactly as in IDLE,
//    so back-to-back rows have a one-cycle DONE between GAP and the next SETUP.
//  - busy=1 exactly in SETUP/ON/GAP; cpv/oe/stv are never high in IDLE or DONE.
//  - Sequence check at accept: legal if row==0, or row==prev+1 with prev+1 < cfg_num_rows.
//    Illegal row still runs the full waveform (stv=0) and sets err_seq.
//  - Overrun: row_strobe while busy is dropped, sets err_overrun; the current row is unaffected.
//  - Last row: after row cfg_num_rows-1 only row 0 is legal; no wrap to 1.
//  - Counters load cfg-1 and count down to 0; no wrap on max values (t_on=65535 holds 65535 cycles).
//  - rst mid-row: outputs drop to 0 in the cycle after the rst edge; no row_done.
// CONFIGURATION
//  GATE_FAST_DUMMY_EN defined: rows with scan_mode=1 use on-time max(t_on>>2,1) for fast
//  reset scans. Not defined: scan_mode is ignored for timing (only latched) and all rows use t_on.
// TESTING
//  1 rst; setup=2,on=5,gap=3; strobe row0 -> stv=cpv=1 for 2 cyc, oe=1 for 5, gap 3, row_done at +11
//  2 rows 0,1,2 each strobed on row_done -> stv only for row0, err_seq=0, cur_row=2
//  3 row0 then row5 -> row5 waveform runs with stv=0, err_seq=1 sticky until rst
//  4 strobe during ON -> ignored, err_overrun=1, current oe length still 5
//  5 gap=0,setup=0,on=0 -> SETUP 1, ON 1, row_done 2 cycles after SETUP start
//  6 rst during ON -> oe/cpv/busy=0 next cycle, no row_done; with GATE_FAST_DUMMY_EN,
//    scan_mode=1,on=20 -> oe high 5 cycles

Source files
------------

// File: rtl/gate_pulse_sequencer_if.sv
// Row request and gate-driver waveform bundle for gate_pulse_sequencer.
// master = row requester (scan engine), slave = sequencer.
interface gate_pulse_sequencer_if #(
  parameter int unsigned ROW_W = 12
);
  logic             row_strobe;
  logic [ROW_W-1:0] row_addr;
  logic             scan_mode;
  logic             gate_stv;
  logic             gate_cpv;
  logic             gate_oe;
  logic             busy;
  logic             row_done;
  logic [ROW_W-1:0] cur_row;

  modport master (
    output row_strobe, row_addr, scan_mode,
    input  gate_stv, gate_cpv, gate_oe, busy, row_done, cur_row
  );

  modport slave (
    input  row_strobe, row_addr, scan_mode,
    output gate_stv, gate_cpv, gate_oe, busy, row_done, cur_row
  );
endinterface

// File: rtl/gate_pulse_sequencer.sv
// Turns row requests into STV/CPV/OE gate-driver waveforms with setup/on/gap timing.
// Optional GATE_FAST_DUMMY_EN: dummy-scan rows (scan_mode=1) use a quarter on-time.
module gate_pulse_sequencer #(
  parameter int unsigned ROW_W = 12,
  parameter int unsigned TW    = 16,
  parameter int unsigned SW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  gate_pulse_sequencer_if.slave bus,
  input  logic [SW-1:0]    cfg_t_setup,
  input  logic [TW-1:0]    cfg_t_on,
  input  logic [SW-1:0]    cfg_t_gap,
  input  logic [ROW_W-1:0] cfg_num_rows,
  output logic             err_overrun,
  output logic             err_seq
);

  localparam int unsigned CW = (TW > SW) ? TW : SW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ON,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [TW-1:0]    on_ld_r;
  logic [SW-1:0]    gap_r;
  logic             scan_mode_r;
  logic [ROW_W-1:0] cur_row_r;
  logic [ROW_W:0]   exp_next;
  logic             accept;
  logic             legal;
  logic [CW-1:0]    setup_ext;
  logic [CW-1:0]    setup_ld;
  logic [TW-1:0]    on_src;
  logic [TW-1:0]    on_ld;
  logic             unused_scan_mode;

  assign unused_scan_mode = scan_mode_r;

  // Zero-valued configs behave as one cycle, so loads saturate at 0 instead of wrapping.
  assign setup_ext = CW'(cfg_t_setup);
  assign setup_ld  = (setup_ext == '0) ? '0 : setup_ext - CW'(1);

`ifdef GATE_FAST_DUMMY_EN
  assign on_src = bus.scan_mode ? (cfg_t_on >> 2) : cfg_t_on;
`else
  assign on_src = cfg_t_on;
`endif
  assign on_ld = (on_src == '0) ? '0 : on_src - TW'(1);

  assign legal = (bus.row_addr == '0) ||
                 (({1'b0, bus.row_addr} == exp_next) && (bus.row_addr < cfg_num_rows));

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    accept       = 1'b0;
    bus.gate_stv = 1'b0;
    bus.gate_cpv = 1'b0;
    bus.gate_oe  = 1'b0;
    bus.busy     = 1'b0;
    bus.row_done = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        bus.row_done = (state == S_DONE);
        if (bus.row_strobe) begin
          accept    = 1'b1;
          state_nxt = S_SETUP;
          cnt_nxt   = setup_ld;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        bus.busy     = 1'b1;
        bus.gate_cpv = 1'b1;
        bus.gate_stv = (cur_row_r == '0);
        if (cnt == '0) begin
          state_nxt = S_ON;
          cnt_nxt   = CW'(on_ld_r);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_ON: begin
        bus.busy    = 1'b1;
        bus.gate_oe = 1'b1;
        if (cnt == '0) begin
          if (gap_r != '0) begin
            state_nxt = S_GAP;
            cnt_nxt   = CW'(gap_r) - CW'(1);
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_GAP: begin
        bus.busy = 1'b1;
        if (cnt == '0) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      on_ld_r     <= '0;
      gap_r       <= '0;
      scan_mode_r <= 1'b0;
      cur_row_r   <= '0;
      exp_next    <= '0;
      err_overrun <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cur_row_r   <= bus.row_addr;
        scan_mode_r <= bus.scan_mode;
        on_ld_r     <= on_ld;
        gap_r       <= cfg_t_gap;
        exp_next    <= {1'b0, bus.row_addr} + (ROW_W+1)'(1);
        if (!legal) err_seq <= 1'b1;
      end
      if (bus.row_strobe && bus.busy) err_overrun <= 1'b1;
    end
  end

  assign bus.cur_row = cur_row_r;

endmodule

// File: tb/tb_gate_pulse_sequencer.sv
// Directed self-checking bench for gate_pulse_sequencer (default or GATE_FAST_DUMMY_EN build).
module tb_gate_pulse_sequencer;
  localparam int unsigned ROW_W  = 12;
  localparam int unsigned TW     = 16;
  localparam int unsigned SW     = 8;
  localparam int          BUDGET = 300;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SW-1:0]    cfg_t_setup = 8'd2;
  logic [TW-1:0]    cfg_t_on = 16'd5;
  logic [SW-1:0]    cfg_t_gap = 8'd3;
  logic [ROW_W-1:0] cfg_num_rows = 12'd8;
  logic             err_overrun;
  logic             err_seq;

  int checks   = 0;
  int failures = 0;
  int stv_n, cpv_n, oe_n, busy_n, done_at, done_cnt, fast_on;

  gate_pulse_sequencer_if #(.ROW_W(ROW_W)) bus ();

  gate_pulse_sequencer #(.ROW_W(ROW_W), .TW(TW), .SW(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cfg_t_setup  (cfg_t_setup),
    .cfg_t_on     (cfg_t_on),
    .cfg_t_gap    (cfg_t_gap),
    .cfg_num_rows (cfg_num_rows),
    .err_overrun  (err_overrun),
    .err_seq      (err_seq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic strobe(input int row, input bit mode);
    bus.row_strobe = 1'b1;
    bus.row_addr   = ROW_W'(row);
    bus.scan_mode  = mode;
    tick();
    bus.row_strobe = 1'b0;
  endtask

  // Samples from the first SETUP cycle (cyc=1) until row_done; inj>0 fires an extra strobe at that cycle.
  task automatic capture(input int inj, output int s, output int c, output int o,
                         output int b, output int d);
    s = 0; c = 0; o = 0; b = 0; d = 0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      if (bus.row_done) begin
        d = cyc;
        break;
      end
      s += int'(bus.gate_stv);
      c += int'(bus.gate_cpv);
      o += int'(bus.gate_oe);
      b += int'(bus.busy);
      if (cyc == inj) strobe(1, 1'b0);
      else tick();
    end
  endtask

  initial begin
    bus.row_strobe = 1'b0;
    bus.row_addr   = '0;
    bus.scan_mode  = 1'b0;
`ifdef GATE_FAST_DUMMY_EN
    fast_on = 5;
`else
    fast_on = 20;
`endif

    // 1: reset state and basic waveform
    do_reset();
    check("rst_stv", bus.gate_stv, 0);
    check("rst_cpv", bus.gate_cpv, 0);
    check("rst_oe", bus.gate_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.row_done, 0);
    check("rst_row", bus.cur_row, 0);
    check("rst_errs", {err_overrun, err_seq}, 0);
    strobe(0, 1'b0);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    check("t1_stv", stv_n, 2);
    check("t1_cpv", cpv_n, 2);
    check("t1_oe", oe_n, 5);
    check("t1_busy", busy_n, 10);
    check("t1_done_at", done_at, 11);
    tick();
    check("t1_done_pulse", bus.row_done, 0);

    // 2: back-to-back legal rows and last-row boundary
    cfg_num_rows = 12'd3;
    do_reset();
    strobe(0, 1'b0);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    check("t2_stv0", stv_n, 2);
    strobe(1, 1'b0);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    check("t2_stv1", stv_n, 0);
    check("t2_done1", done_at, 11);
    strobe(2, 1'b0);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    check("t2_stv2", stv_n, 0);
    check("t2_row", bus.cur_row, 2);
    check("t2_seq", err_seq, 0);
    strobe(0, 1'b0);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    check("t2_wrap0_seq", err_seq, 0);
    strobe(1, 1'b0);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    strobe(2, 1'b0);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    strobe(3, 1'b0);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    check("t2_past_last_seq", err_seq, 1);
    check("t2_past_last_oe", oe_n, 5);

    // 3: out-of-sequence row still runs, err_seq sticky until reset
    cfg_num_rows = 12'd8;
    do_reset();
    strobe(0, 1'b0);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    strobe(5, 1'b0);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    check("t3_stv", stv_n, 0);
    check("t3_oe", oe_n, 5);
    check("t3_done_at", done_at, 11);
    check("t3_seq", err_seq, 1);
    check("t3_row", bus.cur_row, 5);
    strobe(0, 1'b0);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    check("t3_seq_sticky", err_seq, 1);
    do_reset();
    check("t3_seq_clr", err_seq, 0);

    // 4: strobe during ON is dropped
    strobe(0, 1'b0);
    capture(4, stv_n, cpv_n, oe_n, busy_n, done_at);
    check("t4_oe", oe_n, 5);
    check("t4_done_at", done_at, 11);
    check("t4_overrun", err_overrun, 1);
    check("t4_row", bus.cur_row, 0);
    check("t4_seq", err_seq, 0);

    // 5: zero configs
    cfg_t_setup = '0;
    cfg_t_on    = '0;
    cfg_t_gap   = '0;
    do_reset();
    check("t5_overrun_clr", err_overrun, 0);
    strobe(0, 1'b0);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    check("t5_cpv", cpv_n, 1);
    check("t5_oe", oe_n, 1);
    check("t5_busy", busy_n, 2);
    check("t5_done_at", done_at, 3);

    // 6: reset mid-row, then dummy-scan on-time
    cfg_t_setup = 8'd2;
    cfg_t_on    = 16'd5;
    cfg_t_gap   = 8'd3;
    do_reset();
    strobe(0, 1'b0);
    tick();
    tick();
    tick();
    check("t6_in_on", bus.gate_oe, 1);
    rst = 1'b1;
    tick();
    check("t6_oe", bus.gate_oe, 0);
    check("t6_cpv", bus.gate_cpv, 0);
    check("t6_busy", bus.busy, 0);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      done_cnt += int'(bus.row_done);
      tick();
    end
    check("t6_no_done", done_cnt, 0);

    cfg_t_on = 16'd20;
    strobe(0, 1'b1);
    capture(0, stv_n, cpv_n, oe_n, busy_n, done_at);
    check("t6_dummy_oe", oe_n, fast_on);
    check("t6_dummy_done", done_at, 2 + fast_on + 3 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
